noc_output_arbiter: RTL
=======================

# noc_output_arbiter

Per-output-port switch allocator for the 5-port NoC router. One instance sits in front of each active output block. It takes the `request` / `start_of_packet` / `end_of_packet` lines from the five input blocks (east, west, south, north, local) and returns a one-hot `grant`. A grant is locked to one input for the full duration of a wormhole packet, and ownership rotates round-robin between packets.

## Interface
Parameters:
- `NUM_PORTS`, 5: number of requesting input blocks. Index order is east, west, south, north, local.
- `TIMEOUT_CYCLES`, 1024: stall limit, used only when `NOC_ARB_TIMEOUT_EN` is defined. Legal range is 2..65535.

Ports:
- `noc_clk`  in  1: router clock.
- `noc_rst_n`  in  1: asynchronous, active-low reset.
- `request`  in  NUM_PORTS: input i wants this output port.
- `start_of_packet`  in  NUM_PORTS: the head flit of input i is presented.
- `end_of_packet`  in  NUM_PORTS: the tail flit of input i is presented.
- `fire`  in  1: one flit is transferred on this output this cycle (output valid & ready).
- `grant`  out  NUM_PORTS: one-hot or zero, registered. It selects the input that owns the output.
- `owner_idx`  out  $clog2(NUM_PORTS): index of the current owner. Holds its last value when idle.
- `busy`  out  1: registered. Equals |grant.
- `timeout`  out  1: one-cycle pulse when a locked packet is force-released.

## Operation
- State is one bit: IDLE (grant == 0) or LOCKED (grant != 0). There is also a round-robin pointer `rr_ptr` in 0..NUM_PORTS-1.
- Winner selection (combinational):
  - Search starts at `rr_ptr` and wraps modulo NUM_PORTS.
  - The winner is the first i with `request[i]==1` and `start_of_packet[i]==1`.
  - A request without sop is never granted from IDLE, so mid-packet garbage cannot win.
- IDLE:
  - If a winner exists, go to LOCKED with grant = onehot(winner) and owner_idx = winner.
  - Otherwise stay in IDLE.
- LOCKED, owner o:
  - `fire && end_of_packet[o]` is release. Set rr_ptr = (o+1) mod NUM_PORTS.
  - On the same edge, re-arbitrate from the new rr_ptr with the current-cycle requests. A winner gives a direct handover with no bubble; otherwise go to IDLE.
  - In the handover search, input o itself is considered last.
  - `fire` without eop, or no fire: hold grant. Deassertion of `request[o]` mid-packet does not release the lock.
  - Requests, sop and eop from non-owners are ignored while LOCKED.
- Single-flit packet (sop and eop together): it is granted, then released on its own fire.
- `fire` while IDLE is ignored (it is a protocol error; no state change).
- rr_ptr changes only on release, never on grant.
- Reset, asynchronous, any state: grant=0, busy=0, owner_idx=0, timeout=0, rr_ptr=0, timeout counter=0. Any in-flight lock is dropped.

## Timing
- Grant latency: sop+request sampled at edge t gives `grant` high after edge t (visible in cycle t+1).
- Release: a tail fire at edge t drops `grant[o]` after edge t. The next owner's grant is visible in cycle t+1 (zero idle cycles).
- `grant`, `busy`, `owner_idx` and `timeout` are all flops with no combinational path from inputs.
- Worst-case wait for a continuously requesting input is NUM_PORTS-1 packets.

## Configuration
- `NOC_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on grant and on every `fire`, and increments each LOCKED cycle without `fire`.
  - When it reaches TIMEOUT_CYCLES-1 and another cycle passes without fire, the lock is released exactly as on eop. This includes rr_ptr advance and handover.
  - `timeout` pulses for 1 cycle, aligned with the grant drop.
- Not defined: no counter is synthesized, `timeout` is tied to 0, and a lock is held indefinitely until eop.

## Test plan
- Reset, then request=5'b00100 with sop at cycle 0. Expect grant=5'b00100 and owner_idx=2 in cycle 1. A 4-flit packet with fire every cycle and eop on flit 4 gives grant=0 in the cycle after the tail.
- All five requesting with sop continuously, each sending single-flit packets. Expect grant order 0,1,2,3,4,0 with no idle cycle between owners.
- Owner 1 is locked, input 3 asserts request+sop, and owner 1 drops request for 3 cycles mid-packet. Expect grant to stay 5'b00010 until owner 1's eop fire; then grant=5'b01000.
- Asynchronous reset pulse while LOCKED mid-packet. Expect grant=0 immediately. After reset, a request from input 4 is granted with rr_ptr starting at 0.
- request without sop from IDLE on input 0: expect no grant. `fire` pulses while IDLE: expect no state change.
- With `NOC_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=8: lock input 0 and never fire. Expect timeout=1 and grant dropped after the 8th stall cycle, then a handover to pending input 1. Without the macro, the same stimulus holds grant for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/noc_output_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_output_arbiter_if                                        |
// | Description : Request/grant bundle between the five input blocks and one   |
// |               output-port switch allocator.                                |
// |   master : input-block side (drives request, sop, eop, fire)               |
// |   slave  : allocator side   (drives grant, owner_idx, busy, timeout)       |
// |   request         [NUM_PORTS]  input i wants this output port              |
// |   start_of_packet [NUM_PORTS]  head flit of input i is presented           |
// |   end_of_packet   [NUM_PORTS]  tail flit of input i is presented           |
// |   fire                         one flit moves on this output this cycle    |
// |   grant           [NUM_PORTS]  one-hot owner of the output, or zero        |
// |   owner_idx       [IDX_W]      index of the current/last owner             |
// |   busy                         output is locked to an input                |
// |   timeout                      one-cycle pulse on forced release           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface noc_output_arbiter_if #(
  parameter int NUM_PORTS = 5
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] request;
  logic [NUM_PORTS-1:0] start_of_packet;
  logic [NUM_PORTS-1:0] end_of_packet;
  logic                 fire;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     owner_idx;
  logic                 busy;
  logic                 timeout;

  modport master (
    output request, start_of_packet, end_of_packet, fire,
    input  grant, owner_idx, busy, timeout
  );

  modport slave (
    input  request, start_of_packet, end_of_packet, fire,
    output grant, owner_idx, busy, timeout
  );
endinterface
`default_nettype wire

// File: rtl/noc_output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_output_arbiter                                           |
// | Description : Per-output-port wormhole switch allocator. Locks the output  |
// |               to one input from head flit to tail flit and rotates         |
// |               ownership round-robin between packets, with zero-bubble      |
// |               handover on the tail edge.                                   |
// | Ports       : noc_clk    router clock                                      |
// |               noc_rst_n  asynchronous active-low reset                     |
// |               bus        noc_output_arbiter_if.slave (request/sop/eop/     |
// |                          fire in; grant/owner_idx/busy/timeout out)        |
// | Options     : NOC_ARB_TIMEOUT_EN - when defined, a lock that sees          |
// |               TIMEOUT_CYCLES consecutive cycles without fire is released   |
// |               as if its tail had been sent, and timeout pulses. When not   |
// |               defined, no stall counter exists and timeout is 0.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module noc_output_arbiter #(
  parameter int NUM_PORTS      = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    noc_clk,
  input  logic                    noc_rst_n,
  noc_output_arbiter_if.slave     bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_q,  state_d;
  logic [NUM_PORTS-1:0] grant_q,  grant_d;
  logic [IDX_W-1:0]     owner_q,  owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 busy_q;

  logic [NUM_PORTS-1:0] w_cand;
  logic [IDX_W-1:0]     w_owner_next;
  logic [IDX_W-1:0]     w_base;
  logic [IDX_W:0]       w_pos;
  logic                 w_win_found;
  logic [IDX_W-1:0]     w_win_idx;
  logic [NUM_PORTS-1:0] w_win_onehot;
  logic                 w_tail;
  logic                 w_expired;
  logic                 w_release;
  logic                 w_grant_evt;

  // Only a head flit may win; a bare request is mid-packet traffic.
  assign w_cand = bus.request & bus.start_of_packet;

  assign w_owner_next = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

  // While locked the search is only used on release, and then it must start
  // just past the departing owner, which places that owner last in the order.
  assign w_base = (state_q == ST_LOCKED) ? w_owner_next : rr_ptr_q;

  assign w_tail    = bus.fire & bus.end_of_packet[owner_q];
  assign w_release = (state_q == ST_LOCKED) && (w_tail || w_expired);

  // Rotating priority search. Walking from the far end downwards lets the
  // candidate closest to w_base overwrite all others.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_pos       = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_pos = {1'b0, w_base} + (IDX_W + 1)'(k);
      if (w_pos >= (IDX_W + 1)'(NUM_PORTS)) begin
        w_pos = w_pos - (IDX_W + 1)'(NUM_PORTS);
      end
      if (w_cand[w_pos[IDX_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_pos[IDX_W-1:0];
      end
    end
  end

  assign w_win_onehot = NUM_PORTS'(1) << w_win_idx;
  assign w_grant_evt  = w_win_found && ((state_q == ST_IDLE) || w_release);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        // fire in IDLE is a protocol error and deliberately has no effect.
        if (w_win_found) begin
          state_d = ST_LOCKED;
          grant_d = w_win_onehot;
          owner_d = w_win_idx;
        end
      end
      ST_LOCKED: begin
        // Non-owner lines and the owner's request level are ignored here;
        // only a tail fire (or a stall expiry) ends the packet.
        if (w_release) begin
          rr_ptr_d = w_owner_next;
          if (w_win_found) begin
            grant_d = w_win_onehot;
            owner_d = w_win_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= |grant_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner_idx = owner_q;
  assign bus.busy      = busy_q;

`ifdef NOC_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt_q;
  logic        timeout_q;

  // Counts consecutive locked cycles without fire. It is held at zero
  // outside a lock so a fresh grant always starts a full stall window.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= w_expired;
      if ((state_d != ST_LOCKED) || w_grant_evt || bus.fire) begin
        stall_cnt_q <= '0;
      end else begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign w_expired   = (state_q == ST_LOCKED) && !bus.fire &&
                       (stall_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign bus.timeout = timeout_q;
`else
  // The stall limit has no meaning without the stall release logic.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
  assign w_expired            = 1'b0;
  assign bus.timeout          = 1'b0;
`endif

endmodule
`default_nettype wire
